// File: rtl/cu_sched.sv
// cu_sched: round-robin scheduler that hands one of four requesters' commands
// to a shared control unit. Each command runs through IDLE -> ISSUE -> WAIT.
// The command ends either on the unit's done pulse (ack) or when the WAIT
// timer runs out (timeout_err).
module cu_sched #(
   parameter int TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [15:0] op,
   output logic        cmd_valid,
   output logic [1:0]  cmd_sel,
   output logic [3:0]  cmd_op,
   input  logic        cmd_ready,
   input  logic        done,
   output logic [3:0]  gnt,
   output logic [3:0]  ack,
   output logic        timeout_err,
   output logic        busy
);

   // Last legal timer value. The command ends here, so the 8-bit timer never wraps.
   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } state_t;

   state_t      state_reg;
   state_t      state_next;

   logic [1:0]  ptr_reg;
   logic [1:0]  sel_reg;
   logic [3:0]  op_reg;
   logic [3:0]  gnt_reg;
   logic [3:0]  ack_reg;
   logic        timeout_err_reg;
   logic [7:0]  timer_reg;

   // Decode strobes produced by the next-state logic
   logic        take_grant;
   logic        accept_cmd;
   logic        exit_ack;
   logic        exit_timeout;

   // Round-robin search: candidate k is requester (ptr + k) mod 4
   logic [1:0]  cand_idx [4];
   logic [3:0]  cand_hit;
   logic [1:0]  win_idx;
   logic [3:0]  win_op;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_cand
         assign cand_idx[gi] = ptr_reg + 2'(gi);
         assign cand_hit[gi] = req[cand_idx[gi]];
      end
   endgenerate

   // The first candidate that is requesting wins. The lowest search offset has priority.
   always_comb begin
      win_idx = ptr_reg;
      if (cand_hit[0]) begin
         win_idx = cand_idx[0];
      end else if (cand_hit[1]) begin
         win_idx = cand_idx[1];
      end else if (cand_hit[2]) begin
         win_idx = cand_idx[2];
      end else if (cand_hit[3]) begin
         win_idx = cand_idx[3];
      end
   end

   // The winner's opcode field is captured at grant time, so cmd_op stays stable afterwards.
   always_comb begin
      win_op = op[{win_idx, 2'b00} +: 4];
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic and the strobes that steer the datapath registers
   always_comb begin
      state_next   = state_reg;
      take_grant   = 1'b0;
      accept_cmd   = 1'b0;
      exit_ack     = 1'b0;
      exit_timeout = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (|req) begin
               take_grant = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               accept_cmd = 1'b1;
               state_next = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // If done and timer expiry happen in the same cycle, done wins.
            if (done) begin
               exit_ack   = 1'b1;
               state_next = ST_IDLE;
            end else if (timer_reg == TIMER_LAST) begin
               exit_timeout = 1'b1;
               state_next   = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Grant and command registers, timer, round-robin pointer and completion pulses
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_reg         <= 2'd0;
         sel_reg         <= 2'd0;
         op_reg          <= 4'd0;
         gnt_reg         <= 4'd0;
         ack_reg         <= 4'd0;
         timeout_err_reg <= 1'b0;
         timer_reg       <= 8'd0;
      end else begin
         ack_reg         <= 4'd0;
         timeout_err_reg <= 1'b0;

         if (take_grant) begin
            sel_reg <= win_idx;
            op_reg  <= win_op;
            gnt_reg <= 4'b0001 << win_idx;
         end

         if (accept_cmd) begin
            timer_reg <= 8'd0;
         end else if (state_reg == ST_WAIT && !exit_ack && !exit_timeout) begin
            timer_reg <= timer_reg + 8'd1;
         end

         // On either exit, the grant drops in the same cycle as the pulse,
         // and the next search starts just after this winner.
         if (exit_ack || exit_timeout) begin
            gnt_reg <= 4'd0;
            ptr_reg <= sel_reg + 2'd1;
         end
         if (exit_ack) begin
            ack_reg <= 4'b0001 << sel_reg;
         end
         if (exit_timeout) begin
            timeout_err_reg <= 1'b1;
         end
      end
   end

   assign cmd_valid   = (state_reg == ST_ISSUE);
   assign busy        = (state_reg != ST_IDLE);
   assign cmd_sel     = sel_reg;
   assign cmd_op      = op_reg;
   assign gnt         = gnt_reg;
   assign ack         = ack_reg;
   assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_cu_sched.sv
// tb_cu_sched: transaction-level bench for cu_sched. Each transaction is
// described by its request mask, opcodes, ready delay and done delay. The
// expected winner comes from a round-robin pick done with plain arithmetic.
// The expected timing comes from those delays.
module tb_cu_sched;

   localparam int TMO = 15;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] op;
   logic        cmd_valid;
   logic [1:0]  cmd_sel;
   logic [3:0]  cmd_op;
   logic        cmd_ready;
   logic        done;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic        timeout_err;
   logic        busy;

   int n_checks  = 0;
   int n_errors  = 0;
   int model_ptr = 0;
   int txn_no    = 0;

   cu_sched #(.TIMEOUT(TMO)) dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .op          (op),
      .cmd_valid   (cmd_valid),
      .cmd_sel     (cmd_sel),
      .cmd_op      (cmd_op),
      .cmd_ready   (cmd_ready),
      .done        (done),
      .gnt         (gnt),
      .ack         (ack),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Round robin: scan ptr, ptr+1, ... mod 4 and return the first requester that is asking
   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++) begin
         if (r[(p + k) % 4]) return (p + k) % 4;
      end
      return 0;
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_valid"}, 32'(cmd_valid), 0);
      check_val({tag, "_sel"}, 32'(cmd_sel), 0);
      check_val({tag, "_op"}, 32'(cmd_op), 0);
      check_val({tag, "_gnt"}, 32'(gnt), 0);
      check_val({tag, "_ack"}, 32'(ack), 0);
      check_val({tag, "_tmo"}, 32'(timeout_err), 0);
      check_val({tag, "_busy"}, 32'(busy), 0);
   endtask

   // Call in an IDLE cycle; this task ends in the cycle that shows ack/timeout_err.
   // done_dly >= TMO means the unit never answers.
   task automatic run_txn(input logic [3:0] r, input logic [15:0] ops,
                          input int rdy_dly, input int done_dly, input bit drop);
      int         win;
      logic [3:0] wop;
      logic [3:0] onehot;
      bit         hit;
      bit         last;
      win    = rr_pick(r, model_ptr);
      wop    = ops[win*4 +: 4];
      onehot = 4'b0001 << win;
      hit    = (done_dly <= TMO - 1);

      check_val("idle_busy", 32'(busy), 0);
      req       = r;
      op        = ops;
      cmd_ready = 1'($urandom % 2);
      done      = 1'($urandom % 2);
      tick;

      for (int c = 0; c <= rdy_dly; c++) begin
         check_val("iss_valid", 32'(cmd_valid), 1);
         check_val("iss_sel", 32'(cmd_sel), 32'(win));
         check_val("iss_op", 32'(cmd_op), 32'(wop));
         check_val("iss_gnt", 32'(gnt), 32'(onehot));
         check_val("iss_busy", 32'(busy), 1);
         check_val("iss_ack", 32'(ack), 0);
         check_val("iss_tmo", 32'(timeout_err), 0);
         cmd_ready = (c == rdy_dly);
         done      = 1'($urandom % 2);
         tick;
      end

      if (drop) req = 4'd0;

      for (int w = 0; w < TMO; w++) begin
         check_val("wait_valid", 32'(cmd_valid), 0);
         check_val("wait_gnt", 32'(gnt), 32'(onehot));
         check_val("wait_busy", 32'(busy), 1);
         check_val("wait_ack", 32'(ack), 0);
         check_val("wait_tmo", 32'(timeout_err), 0);
         done      = (w == done_dly);
         cmd_ready = 1'($urandom % 2);
         last      = (w == done_dly) || (w == TMO - 1);
         tick;
         if (last) break;
      end
      done      = 1'b0;
      cmd_ready = 1'b0;

      check_val("end_ack", 32'(ack), hit ? 32'(onehot) : 32'd0);
      check_val("end_tmo", 32'(timeout_err), hit ? 32'd0 : 32'd1);
      check_val("end_gnt", 32'(gnt), 0);
      check_val("end_busy", 32'(busy), 0);
      check_val("end_valid", 32'(cmd_valid), 0);

      model_ptr = (win + 1) % 4;
      txn_no++;
      $display("txn %0d req=%b win=%0d op=%h rdy=%0d done=%0d -> %s",
               txn_no, r, win, wop, rdy_dly, done_dly, hit ? "ack" : "timeout");
   endtask

   task automatic idle_gap(input int n);
      req = 4'd0;
      for (int i = 0; i < n; i++) begin
         done      = 1'($urandom % 2);
         cmd_ready = 1'($urandom % 2);
         tick;
         check_val("gap_busy", 32'(busy), 0);
         check_val("gap_valid", 32'(cmd_valid), 0);
         check_val("gap_gnt", 32'(gnt), 0);
         check_val("gap_ack", 32'(ack), 0);
         check_val("gap_tmo", 32'(timeout_err), 0);
      end
      done      = 1'b0;
      cmd_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] ops;
      reset     = 1'b1;
      req       = 4'd0;
      op        = 16'd0;
      cmd_ready = 1'b0;
      done      = 1'b0;
      tick;
      tick;
      check_all_zero("rst");
      reset     = 1'b0;
      model_ptr = 0;

      // Single requester 2 with opcode A; the next search must start at 3
      ops = 16'($urandom);
      ops[11:8] = 4'hA;
      run_txn(4'b0100, ops, 0, 0, 1'b0);
      run_txn(4'b1111, 16'($urandom), 0, 0, 1'b0);

      // All requesting: the pointer has wrapped to 0, so the order is 0,1,2,3,0
      for (int i = 0; i < 5; i++) run_txn(4'b1111, 16'($urandom), 0, 0, 1'b0);

      // Backpressure: ready withheld 5 cycles
      run_txn(4'b0001, 16'($urandom), 5, 0, 1'b0);

      // Timeout on requester 1, after which the search resumes at 2
      run_txn(4'b0010, 16'($urandom), 0, 99, 1'b0);
      run_txn(4'b1111, 16'($urandom), 0, 0, 1'b0);

      // done on the last legal timer value still wins
      run_txn(4'b1000, 16'($urandom), 1, TMO - 1, 1'b0);

      // Requester drops req mid-transaction
      run_txn(4'b0100, 16'($urandom), 2, 3, 1'b1);

      // Reset in the third WAIT cycle
      req = 4'b0010;
      op  = 16'($urandom);
      tick;
      cmd_ready = 1'b1;
      tick;
      cmd_ready = 1'b0;
      tick;
      tick;
      check_val("pre_rst_busy", 32'(busy), 1);
      reset = 1'b1;
      done  = 1'b1;
      tick;
      check_all_zero("midrst");
      reset     = 1'b0;
      done      = 1'b0;
      model_ptr = 0;
      idle_gap(2);
      run_txn(4'b1001, 16'($urandom), 0, 1, 1'b0);

      // Random transactions and idle gaps
      for (int i = 0; i < 250; i++) begin
         logic [3:0] r;
         r = 4'($urandom % 16);
         if (r == 4'd0) begin
            idle_gap(1 + int'($urandom % 3));
         end else begin
            run_txn(r, 16'($urandom), int'($urandom % 4), int'($urandom % 18), 1'($urandom % 2));
         end
      end

      idle_gap(1);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
